pipe_mem_ctrl: RTL and testbench
================================

// Module: pipe_mem_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage 16-bit core: drives write enables, flushes and bubbles of the IF/ID, ID/EX,
//  EX/MEM and MEM/WB registers. Holds the pipe during multi-cycle data-memory accesses, detects load-use hazards and
//  squashes on taken branches. Drains the pipe after HALT reaches MEM. One instance sits beside the EX/MEM register.
// PARAMETERS
//  MEM_TIMEOUT   16  max WAIT cycles before the error state (counter width = clog2(MEM_TIMEOUT+1))
//  DRAIN_CYCLES  2   cycles after HALT leaves MEM before halt_done (covers MEM/WB and WB)
// PORTS
//  clk             in   1  system clock, rising edge
//  rst             in   1  synchronous, active-high reset
//  exmem_memRead   in   1  EX/MEM holds a load
//  exmem_memWrite  in   1  EX/MEM holds a store
//  exmem_halt      in   1  EX/MEM holds HALT
//  mem_done        in   1  data memory finished the current access (may be the same cycle as mem_en)
//  idex_memRead    in   1  ID/EX holds a load
//  idex_writeReg   in   3  destination register of ID/EX
//  ifid_rs/ifid_rt in   3  source registers decoded in ID
//  ifid_rsValid/ifid_rtValid in 1  source is actually read
//  branch_taken    in   1  EX resolved a taken branch/jump this cycle
//  mem_en          out  1  start a data-memory access (1-cycle pulse per access)
//  pc_we, ifid_we, idex_we, exmem_we, memwb_we  out 1 each  stage register write enables
//  ifid_flush      out  1  load NOP into IF/ID
//  idex_bubble     out  1  load NOP (all control bits 0) into ID/EX
//  memwb_bubble    out  1  load NOP into MEM/WB
//  halt_done       out  1  pipe fully drained after HALT; sticky
//  err             out  1  memory timeout; sticky
// BEHAVIOUR
//  States: IDLE, WAIT, DRAIN, HALTED, ERR. Registered: state, tmo_cnt, drain_cnt. Outputs decode from state+inputs.
//  rst: state=IDLE, counters=0. While rst=1, every output is 0 (all *_we, flush, bubble, mem_en, halt_done, err).
//  IDLE, memory op (memRead|memWrite):
//   - mem_en=1.
//   - mem_done=1 same cycle: no stall, stay IDLE.
//   - else: all *_we=0 except memwb_we=1 with memwb_bubble=1, go WAIT, tmo_cnt=0.
//  WAIT: mem_en=0, same hold outputs, tmo_cnt++ each cycle.
//   - mem_done=1: all *_we=1, memwb_bubble=0, go IDLE (exactly one access per instruction).
//   - tmo_cnt==MEM_TIMEOUT-1 without done: go ERR.
//  Priority in IDLE/WAIT: memory hold > branch flush > load-use stall. branch_taken ignored while held (EX frozen,
//   re-evaluated on release).
//  Load-use (IDLE, no memory hold): idex_memRead & ((ifid_rsValid & rs==idex_writeReg)|(ifid_rtValid & rt==idex_writeReg))
//   -> pc_we=0, ifid_we=0, idex_we=1, idex_bubble=1, exmem_we=memwb_we=1. Exactly one bubble per hazard.
//  Branch (IDLE, no hold): ifid_flush=1, idex_bubble=1, all *_we=1. Overrides a simultaneous load-use.
//  Halt: exmem_halt=1 in IDLE (after any memory op of that slot completes) -> go DRAIN, drain_cnt=0. HALT itself
//   never starts an access.
//  DRAIN: pc_we=ifid_we=idex_we=exmem_we=0, memwb_we=1, memwb_bubble=1 after the first cycle, drain_cnt++.
//   drain_cnt==DRAIN_CYCLES-1 -> HALTED.
//  HALTED: all *_we=0, halt_done=1. Leave only by rst.
//  ERR: all *_we=0, mem_en=0, err=1. Leave only by rst.
//  Normal IDLE with no event: all *_we=1, flush/bubble=0.
//  Reset mid-WAIT drops the access; the memory ignores a lost mem_done.
// STRUCTURE
//  Shared include pipe_defs.vh: state encodings (3-bit), NOP control-vector constant, REG_ADDR_W=3.
//  One sub-module: load_use_detect (combinational compare, 1-bit hazard out); FSM and counters stay in the top.
// TESTING
//  1-cycle load (mem_done with mem_en) -> mem_en pulse 1 cycle, all *_we stay 1, no bubble.
//  Store, mem_done 3 cycles after mem_en -> pc/ifid/idex/exmem_we=0 for 3 cycles, memwb_bubble=1 for 3 cycles,
//   release cycle all 1.
//  idex load to r3, ifid rs=3 valid -> one cycle pc_we=ifid_we=0, idex_bubble=1; rs=3 with rsValid=0 -> no stall.
//  branch_taken with simultaneous load-use -> ifid_flush=1, idex_bubble=1, pc_we=1 (branch wins).
//  exmem_halt -> halt_done rises 2 cycles later with default params, stays 1; rst -> halt_done=0, state IDLE.
//  mem_done never asserted -> err=1 after 16 WAIT cycles, all *_we=0; rst clears err.

Source files
------------

// File: rtl/pipe_mem_ctrl_pkg.sv
// Shared types for the pipeline sequencer: state encoding, register address width
// and the stage-control vectors the top selects between each cycle.
package pipe_mem_ctrl_pkg;

  localparam int REG_ADDR_W       = 3;
  localparam int MEM_TIMEOUT_DEF  = 16;
  localparam int DRAIN_CYCLES_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_HALTED = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

  typedef struct packed {
    logic mem_en;
    logic pc_we;
    logic ifid_we;
    logic idex_we;
    logic exmem_we;
    logic memwb_we;
    logic ifid_flush;
    logic idex_bubble;
    logic memwb_bubble;
  } ctrl_t;

  // Field order: mem_en, pc/ifid/idex/exmem/memwb_we, ifid_flush, idex_bubble, memwb_bubble
  localparam ctrl_t CTRL_NOP   = ctrl_t'(9'b0_00000_000);
  localparam ctrl_t CTRL_RUN   = ctrl_t'(9'b0_11111_000);
  localparam ctrl_t CTRL_HOLD  = ctrl_t'(9'b0_00001_001);
  localparam ctrl_t CTRL_FLUSH = ctrl_t'(9'b0_11111_110);
  localparam ctrl_t CTRL_STALL = ctrl_t'(9'b0_00111_010);
  localparam ctrl_t CTRL_DRAIN = ctrl_t'(9'b0_00001_000);

endpackage

// File: rtl/pipe_mem_ctrl_load_use_detect.sv
// Load-use hazard compare between the load in ID/EX and the sources decoded in ID.
// Purely combinational; one hazard bit out.
module load_use_detect
  import pipe_mem_ctrl_pkg::*;
(
  input  logic                  i_idex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_idex_write_reg,
  input  logic [REG_ADDR_W-1:0] i_ifid_rs,
  input  logic [REG_ADDR_W-1:0] i_ifid_rt,
  input  logic                  i_ifid_rs_valid,
  input  logic                  i_ifid_rt_valid,
  output logic                  o_hazard
);

  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit = i_ifid_rs_valid && (i_ifid_rs == i_idex_write_reg);
  assign w_rt_hit = i_ifid_rt_valid && (i_ifid_rt == i_idex_write_reg);
  assign o_hazard = i_idex_mem_read && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/pipe_mem_ctrl.sv
// Pipeline sequencer: stage write enables, flushes and bubbles around memory holds,
// load-use stalls, taken branches and the post-HALT drain. Outputs decode from state + inputs.
module pipe_mem_ctrl
  import pipe_mem_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT  = MEM_TIMEOUT_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exmem_memRead,
  input  logic                  exmem_memWrite,
  input  logic                  exmem_halt,
  input  logic                  mem_done,
  input  logic                  idex_memRead,
  input  logic [REG_ADDR_W-1:0] idex_writeReg,
  input  logic [REG_ADDR_W-1:0] ifid_rs,
  input  logic [REG_ADDR_W-1:0] ifid_rt,
  input  logic                  ifid_rsValid,
  input  logic                  ifid_rtValid,
  input  logic                  branch_taken,
  output logic                  mem_en,
  output logic                  pc_we,
  output logic                  ifid_we,
  output logic                  idex_we,
  output logic                  exmem_we,
  output logic                  memwb_we,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  memwb_bubble,
  output logic                  halt_done,
  output logic                  err
);

  localparam int TMO_W   = $clog2(MEM_TIMEOUT + 1);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  state_t             r_state;
  logic [TMO_W-1:0]   r_tmo_cnt;
  logic [DRAIN_W-1:0] r_drain_cnt;

  logic  w_hazard;
  logic  w_mem_op;
  logic  w_hold;
  ctrl_t w_ctrl;
  logic  w_halt_done;
  logic  w_err;

  load_use_detect u_load_use_detect (
    .i_idex_mem_read  (idex_memRead),
    .i_idex_write_reg (idex_writeReg),
    .i_ifid_rs        (ifid_rs),
    .i_ifid_rt        (ifid_rt),
    .i_ifid_rs_valid  (ifid_rsValid),
    .i_ifid_rt_valid  (ifid_rtValid),
    .o_hazard         (w_hazard)
  );

  assign w_mem_op = exmem_memRead || exmem_memWrite;
  // The access started in IDLE is tracked in WAIT, so WAIT ignores the op bits.
  assign w_hold   = ((r_state == ST_IDLE) && w_mem_op && !mem_done) ||
                    ((r_state == ST_WAIT) && !mem_done);

  always_comb begin
    w_ctrl      = CTRL_NOP;
    w_halt_done = 1'b0;
    w_err       = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_IDLE, ST_WAIT: begin
          if (w_hold)            w_ctrl = CTRL_HOLD;
          else if (branch_taken) w_ctrl = CTRL_FLUSH;
          else if (w_hazard)     w_ctrl = CTRL_STALL;
          else                   w_ctrl = CTRL_RUN;
          w_ctrl.mem_en = (r_state == ST_IDLE) && w_mem_op;
        end
        ST_DRAIN: begin
          w_ctrl              = CTRL_DRAIN;
          w_ctrl.memwb_bubble = (r_drain_cnt != '0);
        end
        ST_HALTED: w_halt_done = 1'b1;
        ST_ERR:    w_err       = 1'b1;
        default:   w_ctrl      = CTRL_NOP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_tmo_cnt   <= '0;
      r_drain_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_mem_op && !mem_done) begin
            r_state   <= ST_WAIT;
            r_tmo_cnt <= '0;
          end else if (exmem_halt) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= '0;
          end
        end
        ST_WAIT: begin
          if (mem_done)                                r_state <= ST_IDLE;
          else if (r_tmo_cnt == TMO_W'(MEM_TIMEOUT - 1)) r_state <= ST_ERR;
          r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
        ST_DRAIN: begin
          if (r_drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) r_state <= ST_HALTED;
          r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
        end
        ST_HALTED: r_state <= ST_HALTED;
        ST_ERR:    r_state <= ST_ERR;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_en       = w_ctrl.mem_en;
  assign pc_we        = w_ctrl.pc_we;
  assign ifid_we      = w_ctrl.ifid_we;
  assign idex_we      = w_ctrl.idex_we;
  assign exmem_we     = w_ctrl.exmem_we;
  assign memwb_we     = w_ctrl.memwb_we;
  assign ifid_flush   = w_ctrl.ifid_flush;
  assign idex_bubble  = w_ctrl.idex_bubble;
  assign memwb_bubble = w_ctrl.memwb_bubble;
  assign halt_done    = w_halt_done;
  assign err          = w_err;

endmodule

// File: tb/tb_pipe_mem_ctrl.sv
// Bench for pipe_mem_ctrl: directed scenarios then random traffic, every cycle
// compared against a behavioural model of the pipeline rules.
module tb_pipe_mem_ctrl;

  localparam int MEM_TIMEOUT  = 16;
  localparam int DRAIN_CYCLES = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, exmem_memRead, exmem_memWrite, exmem_halt, mem_done;
  logic       idex_memRead, ifid_rsValid, ifid_rtValid, branch_taken;
  logic [2:0] idex_writeReg, ifid_rs, ifid_rt;
  logic       mem_en, pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic       ifid_flush, idex_bubble, memwb_bubble, halt_done, err;

  pipe_mem_ctrl dut (
    .clk(clk), .rst(rst),
    .exmem_memRead(exmem_memRead), .exmem_memWrite(exmem_memWrite),
    .exmem_halt(exmem_halt), .mem_done(mem_done),
    .idex_memRead(idex_memRead), .idex_writeReg(idex_writeReg),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_rsValid(ifid_rsValid), .ifid_rtValid(ifid_rtValid),
    .branch_taken(branch_taken),
    .mem_en(mem_en), .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we),
    .exmem_we(exmem_we), .memwb_we(memwb_we), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .memwb_bubble(memwb_bubble),
    .halt_done(halt_done), .err(err)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Model: access outstanding, cycles waited, draining + age, and the two terminal flags.
  bit m_busy, m_drain, m_halted, m_errored;
  int m_wait, m_age;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit load_use();
    return idex_memRead && ((ifid_rsValid && ifid_rs == idex_writeReg) ||
                            (ifid_rtValid && ifid_rt == idex_writeReg));
  endfunction

  // {mem_en, pc, ifid, idex, exmem, memwb, flush, idex_bub, memwb_bub, halt_done, err}
  function automatic logic [10:0] model_out();
    bit en, pc, fi, ix, xm, mw, fl, ib, mb, hd, er, stalled;
    {en, pc, fi, ix, xm, mw, fl, ib, mb, hd, er} = '0;
    if (rst) return '0;
    if (m_errored) er = 1;
    else if (m_halted) hd = 1;
    else if (m_drain) begin
      mw = 1;
      mb = (m_age > 0);
    end else begin
      en      = !m_busy && (exmem_memRead || exmem_memWrite);
      stalled = (m_busy || en) && !mem_done;
      if (stalled) begin
        mw = 1; mb = 1;
      end else begin
        {pc, fi, ix, xm, mw} = 5'b11111;
        if (branch_taken) begin fl = 1; ib = 1; end
        else if (load_use()) begin pc = 0; fi = 0; ib = 1; end
      end
    end
    return {en, pc, fi, ix, xm, mw, fl, ib, mb, hd, er};
  endfunction

  task automatic model_next();
    bit issue, stalled;
    if (rst) begin
      {m_busy, m_drain, m_halted, m_errored} = '0;
      m_wait = 0; m_age = 0;
    end else if (m_errored || m_halted) begin
    end else if (m_drain) begin
      m_age++;
      if (m_age >= DRAIN_CYCLES) begin m_drain = 0; m_halted = 1; end
    end else begin
      issue   = !m_busy && (exmem_memRead || exmem_memWrite);
      stalled = (m_busy || issue) && !mem_done;
      if (stalled) begin
        if (m_busy) begin
          m_wait++;
          if (m_wait >= MEM_TIMEOUT) begin m_errored = 1; m_busy = 0; end
        end else begin
          m_busy = 1; m_wait = 0;
        end
      end else begin
        if (!m_busy && exmem_halt) begin m_drain = 1; m_age = 0; end
        m_busy = 0;
      end
    end
  endtask

  // Called at posedge+1 with inputs already set; samples at posedge+4, returns at next posedge+1.
  task automatic tick(input string tag);
    logic [10:0] obs;
    #3;
    obs = {mem_en, pc_we, ifid_we, idex_we, exmem_we, memwb_we,
           ifid_flush, idex_bubble, memwb_bubble, halt_done, err};
    check_eq(tag, {5'd0, obs}, {5'd0, model_out()});
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    {rst, exmem_memRead, exmem_memWrite, exmem_halt, mem_done} = '0;
    {idex_memRead, ifid_rsValid, ifid_rtValid, branch_taken} = '0;
    idex_writeReg = 3'd0; ifid_rs = 3'd1; ifid_rt = 3'd2;
  endtask

  task automatic randomize_inputs();
    bit mop;
    mop            = ($urandom_range(0, 4) == 0);
    exmem_memRead  = mop && $urandom_range(0, 1);
    exmem_memWrite = mop && !exmem_memRead;
    exmem_halt     = !mop && ($urandom_range(0, 59) == 0);
    mem_done       = ($urandom_range(0, 9) < 4);
    idex_memRead   = ($urandom_range(0, 2) == 0);
    idex_writeReg  = 3'($urandom_range(0, 7));
    ifid_rs        = 3'($urandom_range(0, 7));
    ifid_rt        = 3'($urandom_range(0, 7));
    ifid_rsValid   = $urandom_range(0, 1);
    ifid_rtValid   = $urandom_range(0, 1);
    branch_taken   = ($urandom_range(0, 6) == 0);
    if (m_halted || m_errored) rst = ($urandom_range(0, 7) == 0);
    else                       rst = ($urandom_range(0, 299) == 0);
  endtask

  initial begin
    quiet();
    @(posedge clk); #1;

    // Reset with noisy inputs: all outputs held low.
    for (int i = 0; i < 3; i++) begin
      randomize_inputs(); rst = 1;
      tick("reset");
    end
    quiet();
    tick("idle_run");

    // Single-cycle load.
    exmem_memRead = 1; mem_done = 1;
    tick("load_1cyc");
    quiet(); tick("load_1cyc_after");

    // Store completing 3 cycles after mem_en.
    exmem_memWrite = 1;
    for (int i = 0; i < 3; i++) tick("store_hold");
    mem_done = 1; tick("store_release");
    quiet(); tick("store_after");

    // Load-use on rs, then the invalid-source case.
    idex_memRead = 1; idex_writeReg = 3'd3; ifid_rs = 3'd3; ifid_rsValid = 1;
    tick("load_use");
    idex_memRead = 0; tick("load_use_after");
    idex_memRead = 1; ifid_rsValid = 0; tick("load_use_rs_invalid");

    // Branch beats load-use.
    ifid_rsValid = 1; branch_taken = 1; tick("branch_vs_load_use");
    quiet();

    // Branch frozen during a memory hold, applied on release.
    exmem_memRead = 1; branch_taken = 1; tick("branch_under_hold");
    mem_done = 1; tick("branch_on_release");
    quiet();

    // HALT drain.
    exmem_halt = 1; tick("halt_seen");
    exmem_halt = 0;
    for (int i = 0; i < DRAIN_CYCLES; i++) tick("drain");
    tick("halted");
    tick("halted_sticky");
    check_eq("halt_done_level", {15'd0, halt_done}, 16'd1);
    rst = 1; tick("halt_reset");
    rst = 0; tick("after_halt_reset");
    check_eq("halt_done_cleared", {15'd0, halt_done}, 16'd0);

    // Memory timeout.
    exmem_memRead = 1;
    tick("tmo_issue");
    for (int i = 0; i < MEM_TIMEOUT; i++) tick("tmo_wait");
    tick("tmo_err");
    check_eq("err_level", {15'd0, err}, 16'd1);
    mem_done = 1; tick("err_sticky");
    rst = 1; tick("err_reset");
    quiet(); tick("after_err_reset");
    check_eq("err_cleared", {15'd0, err}, 16'd0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      randomize_inputs();
      tick("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
